fir_tdm_sequencer: RTL
======================

Name: fir_tdm_sequencer

Overview:
Time-division-multiplexed FIR controller for the audio filter path. On each accepted input sample it writes the sample into an internal circular delay line. It then steps one shared multiply-accumulate through all taps, fetching coefficients from an external ROM. Finally it rounds, saturates and emits one filtered output sample, so one multiplier serves all taps.

Parameters:
- TAPS, 32: filter length; power of two, 4..256.
- DW, 16: signed sample width, input and output.
- CW, 16: signed coefficient width, Q1.(CW-1).
- OUT_SHIFT, 15: right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- din_valid  in  1  new sample strobe; sampled only when ready=1
- din  in  DW  signed input sample
- ready  out  1  high in IDLE only
- coef_addr  out  log2(TAPS)  coefficient ROM address
- coef_data  in  CW  signed coefficient; valid exactly 1 cycle after coef_addr (registered ROM)
- dout  out  DW  signed filtered sample; holds its value between valids
- dout_valid  out  1  one-cycle pulse per output
- overrun  out  1  sticky: a sample arrived while busy
- clr_overrun  in  1  clears overrun

Behaviour:
- Reset values: ready=0, dout=0, dout_valid=0, overrun=0, coef_addr=0, write pointer=0, accumulator=0. On reset the state goes to CLEAR.
- Reset mid-operation aborts the current computation. No dout_valid is issued and CLEAR re-runs.
- States: CLEAR -> IDLE -> MAC -> DRAIN -> OUT -> IDLE.
- CLEAR: writes 0 to all TAPS delay-line words, one per cycle, for TAPS cycles, then goes to IDLE. ready=0 throughout.
- IDLE: ready=1. If din_valid=1 at edge n:
  - din is written at the write pointer, and the read pointer is loaded with the write pointer.
  - The write pointer increments mod TAPS.
  - The accumulator clears and the state goes to MAC.
- MAC: TAPS cycles, with tap index k=0..TAPS-1.
  - coef_addr=k.
  - Delay-line read address = (newest - k) mod TAPS, so k=0 reads the sample just written; write-then-read of the same word must return the new value.
  - Reads are synchronous (1 cycle). On the edge after each issue: acc += coef_data * sample.
- DRAIN: 1 cycle, absorbing the last product.
- OUT:
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, an arithmetic shift.
  - r saturates to [-2^(DW-1), 2^(DW-1)-1] and is registered to dout.
  - dout_valid=1 for 1 cycle, and ready returns to 1 in the same cycle.
- Latency: with acceptance at edge n, dout_valid is high at edge n+TAPS+3. Throughput is one sample per TAPS+3 cycles.
- Accumulator width: DW+CW+log2(TAPS). It must not overflow for full-scale inputs and coefficients.
- Overrun:
  - din_valid=1 while ready=0 drops the sample and sets overrun.
  - clr_overrun clears it; if a drop and clr_overrun occur in the same cycle, set wins.
  - A dropped sample never alters the delay line or the output.
- Delay-line pointers wrap mod TAPS with no bubble.

Decomposition:
- Shared package fir_pkg: state enum (CLEAR, IDLE, MAC, DRAIN, OUT), width helper ACC_W = DW+CW+clog2(TAPS), saturation/rounding function.
- One sub-module, fir_delay_ram: TAPS x DW simple dual-port RAM with synchronous read and write-first on same-address collision.
- Coefficient ROM stays external.

Test Plan:
Use TAPS=4 and a bench ROM with coefficients [8192, 16384, -16384, 32767] unless stated otherwise.
1. Reset: deassert rst -> ready=0 for exactly 4 cycles, then 1; dout=0, dout_valid=0, overrun=0.
2. Impulse: din=16384 followed by zeros (each sent when ready=1) -> dout sequence 4096, 8192, -8192, 16384, 0. Each dout_valid arrives 7 edges after acceptance.
3. Saturation: all coefficients 32767, din=32767 repeated -> by the 4th output dout=32767. With din=-32768 repeated -> dout=-32768.
4. Overrun: accept din=16384, pulse din_valid=1 with din=1000 two cycles later -> overrun=1 and the output stream is identical to scenario 2. Then clr_overrun -> overrun=0. Drop and clear in the same cycle -> overrun=1.
5. Reset mid-MAC: accept din=16384, assert rst at tap 2 -> no dout_valid. After CLEAR, an impulse of din=16384 yields 4096 with no residue from the aborted sample.
6. Wrap-around: stream 10 samples of ramp 1000·i with all coefficients 32767 -> each output equals the rounded sum of the last 4 inputs × 32767 / 32768, confirming pointer wrap.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the TDM FIR sequencer.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } state_e;

  // Accumulator width that cannot overflow for full-scale samples and coefficients.
  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Round half-up, arithmetic shift right, then clamp to a signed dw-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift, input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_delay_ram.sv
// Circular delay-line storage: simple dual-port RAM, synchronous read, write-first on collision.
module fir_delay_ram #(
  parameter int DEPTH = 32,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  // NOTE: storage has no reset so it maps onto RAM; the controller zeroes it explicitly.
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_tdm_sequencer.sv
// Time-multiplexed FIR controller: one shared MAC steps through all taps per accepted sample.
module fir_tdm_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS      = 32,
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  input  logic signed [DW-1:0]    din,
  output logic                    ready,
  output logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [CW-1:0]    coef_data,
  output logic signed [DW-1:0]    dout,
  output logic                    dout_valid,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DW + CW;
  localparam int ACC_W = acc_w(DW, CW, TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  state_e                  state_q;
  logic [AW-1:0]           wptr_q;
  logic [AW-1:0]           rptr_q;
  logic [AW-1:0]           coef_addr_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [DW-1:0]    dout_q;
  logic signed [DW-1:0]    dout_d;
  logic                    ready_q;
  logic                    dout_valid_q;
  logic                    overrun_q;

  logic                    accept;
  logic                    drop;
  logic                    ram_we;
  logic [DW-1:0]           ram_wdata;
  logic [DW-1:0]           ram_rdata;
  logic signed [DW-1:0]    sample;
  logic signed [PW-1:0]    prod;

  assign accept = (state_q == ST_IDLE) && din_valid;
  assign drop   = din_valid && !ready_q;

  // CLEAR and sample writes share the write pointer, so CLEAR leaves it back at 0.
  assign ram_we    = !rst && ((state_q == ST_CLEAR) || accept);
  assign ram_wdata = (state_q == ST_CLEAR) ? '0 : din;

  fir_delay_ram #(
    .DEPTH (TAPS),
    .W     (DW)
  ) u_delay (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  assign sample = ram_rdata;
  assign prod   = coef_data * sample;
  assign acc_d  = acc_q + ACC_W'(prod);
  assign dout_d = DW'(round_sat(64'(acc_q), OUT_SHIFT, DW));

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      wptr_q       <= '0;
      rptr_q       <= '0;
      coef_addr_q  <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (drop) overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;

      case (state_q)
        ST_CLEAR: begin
          wptr_q <= wptr_q + 1'b1;
          if (wptr_q == LAST) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (din_valid) begin
            wptr_q      <= wptr_q + 1'b1;
            rptr_q      <= wptr_q;
            coef_addr_q <= '0;
            acc_q       <= '0;
            ready_q     <= 1'b0;
            state_q     <= ST_MAC;
          end
        end
        ST_MAC: begin
          // Tap k's product lands one cycle after its address is issued.
          if (coef_addr_q != '0) acc_q <= acc_d;
          rptr_q <= rptr_q - 1'b1;
          if (coef_addr_q == LAST) begin
            coef_addr_q <= '0;
            state_q     <= ST_DRAIN;
          end else begin
            coef_addr_q <= coef_addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          acc_q   <= acc_d;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          dout_q       <= dout_d;
          dout_valid_q <= 1'b1;
          ready_q      <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign ready      = ready_q;
  assign coef_addr  = coef_addr_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule
